// File: rtl/spi_byte_capture.sv
// rtl/spi_byte_capture.sv - masked-trigger byte capture buffer with pulsed readout
module spi_byte_capture #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              arm,
  input  logic [7:0]        trig_value,
  input  logic [7:0]        trig_mask,
  input  logic [ADDR_W:0]   capture_len,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        dropped
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_arm;
  logic [7:0]        val_q, mask_q;
  logic [ADDR_W:0]   count_q, rd_ptr_q;
  logic [7:0]        dropped_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              done_q;
  logic [7:0]        mem [DEPTH];

  logic              mem_we;
  logic              rd_accept;
  logic              drop_inc;
  logic              trig_hit;

  // A length of zero or anything past the buffer means "fill the whole buffer".
  always_comb begin
    len_arm = capture_len;
    if (capture_len == '0 || capture_len > DEPTH_C) len_arm = DEPTH_C;
  end

  assign trig_hit = ((byte_in ^ val_q) & mask_q) == 8'h00;

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    rd_accept = 1'b0;
    drop_inc  = 1'b0;
    if (arm) begin
      state_d = S_ARMED;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (byte_valid && trig_hit) begin
            mem_we  = 1'b1;
            state_d = (len_q == ONE_C) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (byte_valid) begin
            mem_we = 1'b1;
            if (count_q + ONE_C == len_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          drop_inc  = byte_valid;
          rd_accept = rd_en && (rd_ptr_q < count_q);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      dropped_q  <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= DEPTH_C;
      val_q      <= 8'h00;
      mask_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_d == S_DONE);
      rd_valid_q <= rd_accept;
      if (arm) begin
        count_q   <= '0;
        rd_ptr_q  <= '0;
        dropped_q <= 8'h00;
        len_q     <= len_arm;
        val_q     <= trig_value;
        mask_q    <= trig_mask;
      end else begin
        if (mem_we) count_q <= count_q + ONE_C;
        if (rd_accept) begin
          rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
          rd_ptr_q  <= rd_ptr_q + ONE_C;
        end
        if (drop_inc && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'h01;
      end
    end
  end

  // Trigger byte lands at index 0 because count is zero while ARMED.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[count_q[ADDR_W-1:0]] <= byte_in;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign done     = done_q;
  assign count    = count_q;
  assign dropped  = dropped_q;

endmodule
